// File: rtl/hiscore_tracker.sv
// hiscore_tracker: tracks the peak valid BCD score of a run, commits it to a
// session high score at game over, and drives the display digits, the
// leading-zero blank mask and a blinking new-record flag.
module hiscore_tracker #(
    parameter int unsigned BLINK_TICKS = 8,
    parameter int unsigned HOLD_TICKS  = 48
) (
    input  logic       clk22,
    input  logic       rst,
    input  logic       gamestart,
    input  logic       gameover,
    input  logic [3:0] score0,
    input  logic [3:0] score1,
    input  logic [3:0] score2,
    input  logic [3:0] score3,
    output logic [3:0] disp0,
    output logic [3:0] disp1,
    output logic [3:0] disp2,
    output logic [3:0] disp3,
    output logic [3:0] blank,
    output logic [3:0] hi0,
    output logic [3:0] hi1,
    output logic [3:0] hi2,
    output logic [3:0] hi3,
    output logic       new_record
);

    localparam int unsigned SCORE_W = 16;
    localparam int unsigned TIMER_W = (HOLD_TICKS  > 1) ? $clog2(HOLD_TICKS)  : 1;
    localparam int unsigned BLINK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_PLAY   = 2'd1,
        S_RESULT = 2'd2
    } state_t;

    state_t               state;
    logic [SCORE_W-1:0]   hi_q;
    logic [SCORE_W-1:0]   peak_q;
    logic [SCORE_W-1:0]   disp_q;
    logic [TIMER_W-1:0]   timer_q;
    logic [BLINK_W-1:0]   blink_q;
    logic                 rec_q;

    logic [SCORE_W-1:0]   sample;
    logic                 sample_valid;

    // Leading-zero mask for a 4-digit BCD value; the ones digit is never blanked.
    function automatic logic [3:0] blank_of(input logic [SCORE_W-1:0] d);
        logic b3;
        logic b2;
        logic b1;
        b3 = (d[15:12] == 4'd0);
        b2 = b3 & (d[11:8] == 4'd0);
        b1 = b2 & (d[7:4] == 4'd0);
        return {b3, b2, b1, 1'b0};
    endfunction

    // Assemble the live score and reject samples holding a transient non-BCD digit.
    always_comb begin
        sample       = {score3, score2, score1, score0};
        sample_valid = (score0 <= 4'd9) && (score1 <= 4'd9) &&
                       (score2 <= 4'd9) && (score3 <= 4'd9);
    end

    // Run-tracking state machine with registered display, record and blink outputs.
    always_ff @(posedge clk22) begin
        if (rst) begin
            state      <= S_IDLE;
            hi_q       <= '0;
            peak_q     <= '0;
            disp_q     <= '0;
            blank      <= 4'b1110;
            timer_q    <= '0;
            blink_q    <= '0;
            rec_q      <= 1'b0;
            new_record <= 1'b0;
        end else if (gamestart) begin
            // A new run wins over everything else, including a same-cycle gameover.
            state      <= S_PLAY;
            peak_q     <= '0;
            timer_q    <= '0;
            blink_q    <= '0;
            rec_q      <= 1'b0;
            new_record <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    disp_q <= hi_q;
                    blank  <= blank_of(hi_q);
                end

                S_PLAY: begin
                    if (sample_valid) begin
                        disp_q <= sample;
                        blank  <= blank_of(sample);
                        if (sample > peak_q) begin
                            peak_q <= sample;
                        end
                    end
                    if (gameover) begin
                        state      <= S_RESULT;
                        timer_q    <= '0;
                        blink_q    <= '0;
                        rec_q      <= 1'b0;
                        new_record <= 1'b0;
                    end
                end

                S_RESULT: begin
                    disp_q <= peak_q;
                    blank  <= blank_of(peak_q);

                    // Entry cycle decides the record; later cycles run the blink divider.
                    if (timer_q == '0) begin
                        blink_q <= '0;
                        if (peak_q > hi_q) begin
                            hi_q       <= peak_q;
                            rec_q      <= 1'b1;
                            new_record <= 1'b1;
                        end else begin
                            rec_q      <= 1'b0;
                            new_record <= 1'b0;
                        end
                    end else if (rec_q) begin
                        if (blink_q == BLINK_W'(BLINK_TICKS - 1)) begin
                            blink_q    <= '0;
                            new_record <= ~new_record;
                        end else begin
                            blink_q <= blink_q + BLINK_W'(1);
                        end
                    end

                    if (timer_q == TIMER_W'(HOLD_TICKS - 1)) begin
                        state      <= S_IDLE;
                        timer_q    <= '0;
                        rec_q      <= 1'b0;
                        new_record <= 1'b0;
                    end else begin
                        timer_q <= timer_q + TIMER_W'(1);
                    end
                end

                default: begin
                    state      <= S_IDLE;
                    new_record <= 1'b0;
                end
            endcase
        end
    end

    // Registered digit outputs.
    assign disp0 = disp_q[3:0];
    assign disp1 = disp_q[7:4];
    assign disp2 = disp_q[11:8];
    assign disp3 = disp_q[15:12];
    assign hi0   = hi_q[3:0];
    assign hi1   = hi_q[7:4];
    assign hi2   = hi_q[11:8];
    assign hi3   = hi_q[15:12];

endmodule
